// File: rtl/rice_bus_arbiter_if.sv
// One rice_bus channel, LANES wide on the request/handshake side so the same
// type serves both the per-requester bundle and the single shared master port.
interface rice_bus_arbiter_if #(
    parameter int LANES         = 1,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    localparam int STROBE_WIDTH = DATA_WIDTH / 8;

    logic [LANES-1:0]               request_valid;
    logic [LANES-1:0]               request_ready;
    logic [LANES-1:0]               write;
    logic [LANES*ADDRESS_WIDTH-1:0] address;
    logic [LANES*STROBE_WIDTH-1:0]  strobe;
    logic [LANES*DATA_WIDTH-1:0]    write_data;
    logic [LANES-1:0]               response_valid;
    logic [LANES-1:0]               response_ready;
    // Read data is shared by every lane; response_valid says who owns it.
    logic [DATA_WIDTH-1:0]          read_data;

    modport master (
        output request_valid, write, address, strobe, write_data, response_ready,
        input  request_ready, response_valid, read_data
    );

    modport slave (
        input  request_valid, write, address, strobe, write_data, response_ready,
        output request_ready, response_valid, read_data
    );
endinterface

// File: rtl/rice_bus_arbiter.sv
// N-to-1 rice_bus arbiter: round-robin grant held until accept, reads tracked
// in an ID FIFO so in-order responses return to the requester that issued them.
module rice_bus_arbiter #(
    parameter int REQUESTERS      = 2,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    rice_bus_arbiter_if.slave  req,
    rice_bus_arbiter_if.master mem
);
    localparam int STROBE_WIDTH = DATA_WIDTH / 8;
    localparam int INDEX_WIDTH  = $clog2(REQUESTERS);
    localparam int SLOT_WIDTH   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int COUNT_WIDTH  = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {IDLE, LOCKED} state_t;
    typedef logic [INDEX_WIDTH-1:0] index_t;
    typedef logic [SLOT_WIDTH-1:0]  slot_t;

    function automatic index_t next_index(input index_t idx);
        return (int'(idx) == REQUESTERS - 1) ? '0 : index_t'(int'(idx) + 1);
    endfunction

    function automatic slot_t next_slot(input slot_t slot);
        return (int'(slot) == MAX_OUTSTANDING - 1) ? '0 : slot_t'(int'(slot) + 1);
    endfunction

    state_t                 state;
    index_t                 pointer;
    index_t                 locked_index;
    index_t                 id_fifo [MAX_OUTSTANDING];
    slot_t                  wr_slot;
    slot_t                  rd_slot;
    logic [COUNT_WIDTH-1:0] count;

    index_t scan_index;
    logic   scan_found;
    index_t grant;
    logic   granted;
    logic   full;
    logic   empty;
    logic   accept;
    logic   push;
    logic   pop;
    index_t head;

    always_comb begin
        index_t idx;
        idx        = pointer;
        scan_index = pointer;
        scan_found = 1'b0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (!scan_found && req.request_valid[idx]) begin
                scan_found = 1'b1;
                scan_index = idx;
            end
            idx = next_index(idx);
        end
    end

    assign full    = (count == COUNT_WIDTH'(MAX_OUTSTANDING));
    assign empty   = (count == '0);
    assign grant   = (state == LOCKED) ? locked_index : scan_index;
    assign granted = (state == LOCKED) || scan_found;

    // Outputs are gated by reset so they drop the instant i_rst_n falls.
    assign mem.request_valid = i_rst_n & granted & req.request_valid[grant] & ~full;
    assign mem.write         = req.write[grant];
    assign mem.address       = req.address[int'(grant)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign mem.strobe        = req.strobe[int'(grant)*STROBE_WIDTH +: STROBE_WIDTH];
    assign mem.write_data    = req.write_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        req.request_ready = '0;
        if (i_rst_n && granted && !full) begin
            req.request_ready[grant] = mem.request_ready;
        end
    end

    assign accept = mem.request_valid & mem.request_ready;
    assign push   = accept & ~mem.write;
    assign pop    = mem.response_valid & mem.response_ready;
    assign head   = id_fifo[rd_slot];

    // With nothing outstanding a master response has no owner and is stalled.
    always_comb begin
        req.response_valid = '0;
        mem.response_ready = 1'b0;
        if (!empty) begin
            req.response_valid[head] = mem.response_valid;
            mem.response_ready       = req.response_ready[head];
        end
    end

    assign req.read_data = mem.read_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            pointer      <= '0;
            locked_index <= '0;
        end else begin
            if (accept) begin
                pointer <= next_index(grant);
            end
            case (state)
                IDLE: begin
                    if (mem.request_valid && !mem.request_ready) begin
                        state        <= LOCKED;
                        locked_index <= grant;
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_slot <= '0;
            rd_slot <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                wr_slot <= next_slot(wr_slot);
            end
            if (pop) begin
                rd_slot <= next_slot(rd_slot);
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_WIDTH'(1);
                2'b01:   count <= count - COUNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    // ID storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge i_clk) begin
        if (push) begin
            id_fifo[wr_slot] <= grant;
        end
    end

    // A locked requester must keep its request valid and its payload stable.
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (state == LOCKED) |-> req.request_valid[locked_index]);

    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (state == LOCKED && req.request_valid[locked_index]) |->
            ($stable(mem.address) && $stable(mem.write) &&
             $stable(mem.strobe) && $stable(mem.write_data)));

    assert property (@(posedge i_clk) disable iff (!i_rst_n) !(push && full));
    assert property (@(posedge i_clk) disable iff (!i_rst_n) !(pop && empty));

endmodule

// File: tb/tb_rice_bus_arbiter.sv
// Directed bench for rice_bus_arbiter with a queue-based reference model
// checked on every falling edge plus literal expectations per scenario.
module tb_rice_bus_arbiter;
    localparam int N    = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int MAXO = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rice_bus_arbiter_if #(.LANES(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) rq();
    rice_bus_arbiter_if #(.LANES(1), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) ms();

    rice_bus_arbiter #(
        .REQUESTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .req     (rq),
        .mem     (ms)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: rotating priority pointer, lock flag, queue of read owners.
    int m_ptr;
    bit m_locked;
    int m_lidx;
    int m_q[$];

    always @(negedge clk) begin : scoreboard
        int             g;
        int             head;
        bit             found;
        bit             full;
        logic           exp_mv;
        logic [N-1:0]   exp_rr;
        logic [N-1:0]   exp_rv;
        logic           exp_mrr;
        if (!rst_n) begin
            m_ptr    = 0;
            m_locked = 0;
            m_lidx   = 0;
            m_q.delete();
            check("rst_mvalid", ms.request_valid, 0);
            check("rst_rready", rq.request_ready, 0);
            check("rst_rvalid", rq.response_valid, 0);
            check("rst_mrready", ms.response_ready, 0);
        end else begin
            full  = (m_q.size() == MAXO);
            found = m_locked;
            g     = m_lidx;
            if (!m_locked) begin
                for (int k = 0; k < N; k++) begin
                    if (!found && rq.request_valid[(m_ptr + k) % N]) begin
                        found = 1;
                        g     = (m_ptr + k) % N;
                    end
                end
            end
            exp_mv = found && !full && rq.request_valid[g];
            exp_rr = '0;
            if (found && !full && ms.request_ready) exp_rr[g] = 1'b1;
            check("m_mvalid", ms.request_valid, exp_mv);
            check("m_rready", rq.request_ready, exp_rr);
            if (exp_mv) begin
                check("m_write", ms.write, rq.write[g]);
                check("m_addr", ms.address, rq.address[g*AW +: AW]);
                check("m_strobe", ms.strobe, rq.strobe[g*SW +: SW]);
                check("m_wdata", ms.write_data, rq.write_data[g*DW +: DW]);
            end
            exp_rv  = '0;
            exp_mrr = 1'b0;
            if (m_q.size() > 0) begin
                head         = m_q[0];
                exp_rv[head] = ms.response_valid;
                exp_mrr      = rq.response_ready[head];
            end
            check("m_rvalid", rq.response_valid, exp_rv);
            check("m_mrready", ms.response_ready, exp_mrr);
            check("m_rdata", rq.read_data, ms.read_data);
            if (m_q.size() > 0 && ms.response_valid && exp_mrr) void'(m_q.pop_front());
            if (exp_mv && ms.request_ready) begin
                m_ptr    = (g + 1) % N;
                m_locked = 0;
                if (!rq.write[g]) m_q.push_back(g);
            end else if (exp_mv) begin
                m_locked = 1;
                m_lidx   = g;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic req_set(input int k, input logic wr, input logic [AW-1:0] a,
                           input logic [SW-1:0] s, input logic [DW-1:0] d);
        rq.write[k]               = wr;
        rq.address[k*AW +: AW]    = a;
        rq.strobe[k*SW +: SW]     = s;
        rq.write_data[k*DW +: DW] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required test end");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        rq.request_valid  = '0;
        rq.write          = '0;
        rq.address        = '0;
        rq.strobe         = '0;
        rq.write_data     = '0;
        rq.response_ready = 2'b11;
        ms.request_ready  = 1'b0;
        ms.response_valid = 1'b0;
        ms.read_data      = '0;
        tick();
        tick();
        at_neg();
        check("reset_mvalid", ms.request_valid, 0);
        check("reset_rvalid", rq.response_valid, 0);
        tick();
        rst_n = 1'b1;

        // Single read from requester 0, then its response.
        req_set(0, 1'b0, 32'h100, 4'hF, 32'h0);
        rq.request_valid = 2'b01;
        ms.request_ready = 1'b1;
        at_neg();
        check("t1_mvalid", ms.request_valid, 1);
        check("t1_addr", ms.address, 32'h100);
        check("t1_rready", rq.request_ready, 2'b01);
        tick();
        rq.request_valid  = 2'b00;
        ms.response_valid = 1'b1;
        ms.read_data      = 32'hDEADBEEF;
        at_neg();
        check("t1_rvalid", rq.response_valid, 2'b01);
        check("t1_rdata", rq.read_data, 32'hDEADBEEF);
        check("t1_mrready", ms.response_ready, 1);
        tick();
        at_neg();
        check("t1_stray_rvalid", rq.response_valid, 2'b00);
        check("t1_stray_mrready", ms.response_ready, 0);
        tick();
        ms.response_valid = 1'b0;

        // Requester 1 write brings the pointer back to 0.
        req_set(1, 1'b1, 32'h40, 4'hF, 32'h1);
        rq.request_valid = 2'b10;
        at_neg();
        check("t2_pre_rready", rq.request_ready, 2'b10);
        tick();

        // Both requesters continuously valid: alternating grants.
        req_set(0, 1'b1, 32'h10, 4'hF, 32'hA);
        req_set(1, 1'b1, 32'h14, 4'hF, 32'hB);
        rq.request_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            check($sformatf("t2_grant%0d", i), rq.request_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        rq.request_valid = 2'b00;

        // Stalled master: grant locked on requester 0 while requester 1 waits.
        req_set(0, 1'b0, 32'h200, 4'hF, 32'h0);
        req_set(1, 1'b0, 32'h300, 4'hF, 32'h0);
        rq.request_valid = 2'b01;
        ms.request_ready = 1'b0;
        at_neg();
        check("t3_c1_addr", ms.address, 32'h200);
        check("t3_c1_rready", rq.request_ready, 2'b00);
        tick();
        rq.request_valid = 2'b11;
        at_neg();
        check("t3_c2_addr", ms.address, 32'h200);
        tick();
        at_neg();
        check("t3_c3_addr", ms.address, 32'h200);
        tick();
        ms.request_ready = 1'b1;
        at_neg();
        check("t3_c4_addr", ms.address, 32'h200);
        check("t3_c4_rready", rq.request_ready, 2'b01);
        tick();
        rq.request_valid = 2'b10;
        at_neg();
        check("t3_c5_addr", ms.address, 32'h300);
        check("t3_c5_rready", rq.request_ready, 2'b10);
        tick();
        rq.request_valid  = 2'b00;
        ms.response_valid = 1'b1;
        ms.read_data      = 32'h11111111;
        at_neg();
        check("t3_resp0", rq.response_valid, 2'b01);
        tick();
        ms.read_data = 32'h22222222;
        at_neg();
        check("t3_resp1", rq.response_valid, 2'b10);
        tick();
        ms.response_valid = 1'b0;

        // Fill the ID FIFO, then free one slot.
        req_set(0, 1'b0, 32'h400, 4'hF, 32'h0);
        rq.request_valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            check($sformatf("t4_acc%0d", i), rq.request_ready, 2'b01);
            tick();
        end
        ms.response_valid = 1'b1;
        ms.read_data      = 32'hA0;
        at_neg();
        check("t4_full_mvalid", ms.request_valid, 0);
        check("t4_full_rready", rq.request_ready, 2'b00);
        check("t4_pop_rvalid", rq.response_valid, 2'b01);
        tick();
        ms.response_valid = 1'b0;
        at_neg();
        check("t4_fifth_mvalid", ms.request_valid, 1);
        check("t4_fifth_rready", rq.request_ready, 2'b01);
        tick();
        rq.request_valid  = 2'b00;
        ms.response_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            check($sformatf("t4_drain%0d", i), rq.response_valid, 2'b01);
            tick();
        end
        ms.response_valid = 1'b0;

        // Reads 0,1,0 then responses A,B,C with requester 1 back-pressuring.
        req_set(0, 1'b0, 32'h500, 4'hF, 32'h0);
        req_set(1, 1'b0, 32'h504, 4'hF, 32'h0);
        rq.request_valid = 2'b01;
        at_neg();
        check("t5_g0", rq.request_ready, 2'b01);
        tick();
        rq.request_valid = 2'b10;
        at_neg();
        check("t5_g1", rq.request_ready, 2'b10);
        tick();
        rq.request_valid = 2'b01;
        at_neg();
        check("t5_g2", rq.request_ready, 2'b01);
        tick();
        rq.request_valid  = 2'b00;
        ms.response_valid = 1'b1;
        ms.read_data      = 32'hAAAA0000;
        at_neg();
        check("t5_respA", rq.response_valid, 2'b01);
        check("t5_dataA", rq.read_data, 32'hAAAA0000);
        tick();
        ms.read_data      = 32'hBBBB0000;
        rq.response_ready = 2'b01;
        at_neg();
        check("t5_B_hold_mrready", ms.response_ready, 0);
        check("t5_B_rvalid", rq.response_valid, 2'b10);
        tick();
        at_neg();
        check("t5_B_hold2_mrready", ms.response_ready, 0);
        tick();
        rq.response_ready = 2'b11;
        at_neg();
        check("t5_B_release_mrready", ms.response_ready, 1);
        tick();
        ms.read_data = 32'hCCCC0000;
        at_neg();
        check("t5_respC", rq.response_valid, 2'b01);
        tick();
        ms.response_valid = 1'b0;

        // Write with partial strobe, then a read whose response must go to requester 0.
        req_set(1, 1'b1, 32'h600, 4'b0011, 32'hCAFEF00D);
        rq.request_valid = 2'b10;
        at_neg();
        check("t6_write", ms.write, 1);
        check("t6_strobe", ms.strobe, 4'b0011);
        check("t6_wdata", ms.write_data, 32'hCAFEF00D);
        tick();
        req_set(0, 1'b0, 32'h604, 4'hF, 32'h0);
        rq.request_valid = 2'b01;
        tick();
        rq.request_valid  = 2'b00;
        ms.response_valid = 1'b1;
        ms.read_data      = 32'h12345678;
        at_neg();
        check("t6_resp_owner", rq.response_valid, 2'b01);
        check("t6_resp_data", rq.read_data, 32'h12345678);
        tick();
        ms.response_valid = 1'b0;

        // Two outstanding reads, then asynchronous reset mid-cycle.
        rq.request_valid = 2'b01;
        tick();
        tick();
        ms.response_valid = 1'b1;
        #1;
        check("t6_pre_rvalid", rq.response_valid, 2'b01);
        check("t6_pre_mvalid", ms.request_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_mvalid", ms.request_valid, 0);
        check("t6_rst_rready", rq.request_ready, 2'b00);
        check("t6_rst_rvalid", rq.response_valid, 2'b00);
        check("t6_rst_mrready", ms.response_ready, 0);
        tick();
        rq.request_valid = 2'b00;
        rst_n = 1'b1;
        at_neg();
        check("t6_after_rvalid", rq.response_valid, 2'b00);
        check("t6_after_mrready", ms.response_ready, 0);
        tick();
        ms.response_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
